robs_mult_arbiter: RTL and testbench

//  Shares one Robertson's multiplier datapath and its control FSM between N_REQ requesters.

---
 rtl/robs_mult_arbiter_if.sv | 27 ++
 rtl/robs_mult_arbiter.sv | 128 ++++++++++++
 tb/tb_robs_mult_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/robs_mult_arbiter_if.sv
// rtl/robs_mult_arbiter_if.sv - client request and response bundle for the shared multiplier arbiter
interface robs_mult_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_in;
  logic [N_REQ*WIDTH-1:0] b_in;
  logic [N_REQ-1:0]       ack;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [2*WIDTH-1:0]     rsp_product;
  logic                   rsp_err;

  modport master (
    output req, a_in, b_in, rsp_ready,
    input  ack, rsp_valid, rsp_id, rsp_product, rsp_err
  );

  modport slave (
    input  req, a_in, b_in, rsp_ready,
    output ack, rsp_valid, rsp_id, rsp_product, rsp_err
  );
endinterface

// File: rtl/robs_mult_arbiter.sv
// rtl/robs_mult_arbiter.sv - round-robin arbiter and job sequencer sharing one multiplier between clients
module robs_mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 63
) (
  input  logic                 clk,
  input  logic                 reset,
  robs_mult_arbiter_if.slave   bus,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic                 mul_done,
  input  logic [2*WIDTH-1:0]   mul_product
);
  localparam int IDW = $clog2(N_REQ);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     idx;
  logic [IDW-1:0]     winner;
  logic               found;
  logic [IDW-1:0]     rsp_id_q;
  logic [7:0]         cnt;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic [2*WIDTH-1:0] product_q;
  logic               err_q;
  logic [N_REQ-1:0]   ack_v;
  logic               rsp_valid_v;

  // First requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDW'((int'(ptr) + k) % N_REQ);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (IDW'(k) == winner) begin
        sel_a = bus.a_in[k*WIDTH +: WIDTH];
        sel_b = bus.b_in[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if (mul_done || cnt == CNT_LAST) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mul_done only matters in RUN; a sticky done left over from the previous job is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      rsp_id_q  <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      product_q <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            mul_a    <= sel_a;
            mul_b    <= sel_b;
            rsp_id_q <= winner;
          end
        end
        START: cnt <= '0;
        RUN: begin
          cnt <= cnt + 8'd1;
          if (mul_done) begin
            product_q <= mul_product;
            err_q     <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            product_q <= '0;
            err_q     <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready)
            ptr <= (rsp_id_q == IDW'(N_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack_v = '0;
    if (state == START) ack_v[rsp_id_q] = 1'b1;
    mul_start   = (state == START);
    rsp_valid_v = (state == RESP);
  end

  assign bus.ack         = ack_v;
  assign bus.rsp_valid   = rsp_valid_v;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_product = product_q;
  assign bus.rsp_err     = err_q;
endmodule

// File: tb/tb_robs_mult_arbiter.sv
// tb/tb_robs_mult_arbiter.sv - directed bench with a transaction-level reference model of the arbiter
module tb_robs_mult_arbiter;
  localparam int N_REQ   = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 63;
  localparam int MUL_LAT = 5;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 mul_start;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_product;

  robs_mult_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  robs_mult_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_product (mul_product)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Multiplier stand-in: done rises MUL_LAT cycles after a start pulse and stays until the next one.
  logic hang = 1'b0;
  int   mcnt = 0;
  initial begin
    mul_done    = 1'b0;
    mul_product = '0;
  end
  always @(negedge clk) begin
    if (mul_start) begin
      mul_done    = 1'b0;
      mcnt        = MUL_LAT;
      mul_product = $signed(mul_a) * $signed(mul_b);
    end else if (!hang && mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) mul_done = 1'b1;
    end
  end

  logic signed [WIDTH-1:0] a_op [N_REQ];
  logic signed [WIDTH-1:0] b_op [N_REQ];

  task automatic set_op(input int i, input int a, input int b);
    a_op[i] = WIDTH'(a);
    b_op[i] = WIDTH'(b);
    bus.a_in[i*WIDTH +: WIDTH] = WIDTH'(a);
    bus.b_in[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  function automatic int rr_pick(input int p, input logic [N_REQ-1:0] r);
    for (int d = 0; d < N_REQ; d++)
      if (r[(p + d) % N_REQ]) return (p + d) % N_REQ;
    return -1;
  endfunction

  // Reference model: 0 free, 1 granted, 2 waiting on multiplier, 3 holding a response.
  int     mode = 0;
  int     m_ptr = 0;
  int     m_id = 0;
  int     m_run = 0;
  int     m_err = 0;
  longint m_prod = 0;
  longint m_rsp_prod = 0;
  int     n_start = 0;

  always @(posedge clk) begin
    int w;
    int e_ack;
    int e_start;
    #1;
    e_ack = 0;
    e_start = 0;
    if (mul_start) n_start++;
    if (reset) begin
      mode  = 0;
      m_ptr = 0;
      check("rst_ack", longint'(bus.ack), 0);
      check("rst_valid", longint'(bus.rsp_valid), 0);
      check("rst_start", longint'(mul_start), 0);
      check("rst_err", longint'(bus.rsp_err), 0);
      check("rst_id", longint'(bus.rsp_id), 0);
      check("rst_prod", longint'(bus.rsp_product), 0);
      check("rst_mul_a", longint'(mul_a), 0);
      check("rst_mul_b", longint'(mul_b), 0);
    end else begin
      case (mode)
        0: begin
          if (bus.req != '0) begin
            w       = rr_pick(m_ptr, bus.req);
            e_ack   = 1 << w;
            e_start = 1;
            m_id    = w;
            m_prod  = a_op[w] * b_op[w];
            check("grant_mul_a", longint'($signed(mul_a)), longint'(a_op[w]));
            check("grant_mul_b", longint'($signed(mul_b)), longint'(b_op[w]));
            check("grant_id", longint'(bus.rsp_id), w);
            mode = 1;
          end
        end
        1: begin
          mode  = 2;
          m_run = 0;
        end
        2: begin
          m_run++;
          if (mul_done) begin
            mode = 3; m_err = 0; m_rsp_prod = m_prod;
          end else if (m_run == TIMEOUT) begin
            mode = 3; m_err = 1; m_rsp_prod = 0;
          end
        end
        default: begin
          if (bus.rsp_ready) begin
            mode  = 0;
            m_ptr = (m_id + 1) % N_REQ;
          end
        end
      endcase
      check("ack", longint'(bus.ack), e_ack);
      check("mul_start", longint'(mul_start), e_start);
      check("rsp_valid", longint'(bus.rsp_valid), (mode == 3) ? 1 : 0);
      if (mode == 3) begin
        check("rsp_id", longint'(bus.rsp_id), m_id);
        check("rsp_product", longint'($signed(bus.rsp_product)), m_rsp_prod);
        check("rsp_err", longint'(bus.rsp_err), m_err);
      end
    end
  end

  task automatic wait_ack(input int limit, output int idx, output int cyc);
    idx = -1;
    cyc = 0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (bus.ack != '0) begin
        for (int i = 0; i < N_REQ; i++) if (bus.ack[i]) idx = i;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL wait_ack: no ack within %0d cycles", limit);
  endtask

  task automatic wait_valid(input int limit, output int cyc);
    cyc = 0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (bus.rsp_valid) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_valid: no rsp_valid within %0d cycles", limit);
  endtask

  task automatic wait_rsp(output int id, output longint prod, output int err, output int cyc);
    wait_valid(200, cyc);
    id   = int'(bus.rsp_id);
    prod = longint'($signed(bus.rsp_product));
    err  = int'(bus.rsp_err);
    @(negedge clk);
  endtask

  initial begin
    int idx, cyc, id, err, s0;
    longint prod;
    bus.req = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) set_op(i, 0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: single job, client 0
    s0 = n_start;
    set_op(0, 3, -5);
    bus.req[0] = 1'b1;
    wait_ack(20, idx, cyc);
    bus.req[0] = 1'b0;
    check("t1_ack_id", idx, 0);
    check("t1_ack_latency", cyc, 1);
    wait_rsp(id, prod, err, cyc);
    check("t1_done_to_rsp", cyc, MUL_LAT + 1);
    check("t1_id", id, 0);
    check("t1_prod", prod, -15);
    check("t1_err", err, 0);
    check("t1_start_pulses", n_start - s0, 1);

    // 2: all four requesting, then 0 and 2 together
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    set_op(0, 10, 7);
    set_op(1, -20, 7);
    set_op(2, 30, -3);
    set_op(3, -40, -3);
    bus.req = 4'b1111;
    for (int k = 0; k < N_REQ; k++) begin
      wait_ack(100, idx, cyc);
      if (idx >= 0) bus.req[idx] = 1'b0;
      check("t2_grant_order", idx, k);
    end
    wait_rsp(id, prod, err, cyc);
    check("t2_last_prod", prod, 120);
    bus.req = 4'b0101;
    wait_ack(20, idx, cyc);
    if (idx >= 0) bus.req[idx] = 1'b0;
    check("t2_regrant_first", idx, 0);
    wait_ack(100, idx, cyc);
    if (idx >= 0) bus.req[idx] = 1'b0;
    check("t2_regrant_second", idx, 2);
    wait_rsp(id, prod, err, cyc);
    check("t2_c2_prod", prod, -90);

    // 3: backpressure in RESP with another client pending
    bus.rsp_ready = 1'b0;
    set_op(1, 9, 9);
    set_op(3, 2, 2);
    bus.req[1] = 1'b1;
    wait_ack(20, idx, cyc);
    bus.req[1] = 1'b0;
    bus.req[3] = 1'b1;
    wait_valid(100, cyc);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_hold_valid", longint'(bus.rsp_valid), 1);
      check("t3_hold_id", longint'(bus.rsp_id), 1);
      check("t3_hold_prod", longint'($signed(bus.rsp_product)), 81);
      check("t3_no_ack", longint'(bus.ack), 0);
      check("t3_no_start", longint'(mul_start), 0);
    end
    bus.rsp_ready = 1'b1;
    wait_ack(20, idx, cyc);
    bus.req[3] = 1'b0;
    check("t3_pending_grant", idx, 3);
    wait_rsp(id, prod, err, cyc);
    check("t3_c3_prod", prod, 4);

    // 4: multiplier never finishes, then a normal job on client 1
    hang = 1'b1;
    set_op(2, 5, 6);
    bus.req[2] = 1'b1;
    wait_ack(20, idx, cyc);
    bus.req[2] = 1'b0;
    wait_rsp(id, prod, err, cyc);
    check("t4_timeout_latency", cyc, TIMEOUT + 1);
    check("t4_id", id, 2);
    check("t4_err", err, 1);
    check("t4_prod", prod, 0);
    hang = 1'b0;
    set_op(1, -7, 8);
    bus.req[1] = 1'b1;
    wait_ack(20, idx, cyc);
    bus.req[1] = 1'b0;
    wait_rsp(id, prod, err, cyc);
    check("t4_next_err", err, 0);
    check("t4_next_prod", prod, -56);

    // 5: reset mid-RUN; ptr would favour client 2 if it survived reset
    set_op(2, 4, 4);
    bus.req[2] = 1'b1;
    wait_ack(20, idx, cyc);
    check("t5_first_grant", idx, 2);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_ack", longint'(bus.ack), 0);
    check("t5_rst_valid", longint'(bus.rsp_valid), 0);
    check("t5_rst_start", longint'(mul_start), 0);
    check("t5_rst_mul_a", longint'(mul_a), 0);
    set_op(1, 11, -3);
    bus.req[1] = 1'b1;
    reset = 1'b0;
    wait_ack(20, idx, cyc);
    if (idx >= 0) bus.req[idx] = 1'b0;
    check("t5_after_reset_grant", idx, 1);
    wait_ack(100, idx, cyc);
    if (idx >= 0) bus.req[idx] = 1'b0;
    check("t5_second_grant", idx, 2);
    wait_rsp(id, prod, err, cyc);
    check("t5_c2_prod", prod, 16);

    // 6: extreme operands
    set_op(0, -128, -128);
    bus.req[0] = 1'b1;
    wait_ack(20, idx, cyc);
    bus.req[0] = 1'b0;
    wait_rsp(id, prod, err, cyc);
    check("t6_minmin_prod", prod, 16384);
    set_op(3, 127, -128);
    bus.req[3] = 1'b1;
    wait_ack(20, idx, cyc);
    bus.req[3] = 1'b0;
    wait_rsp(id, prod, err, cyc);
    check("t6_maxmin_id", id, 3);
    check("t6_maxmin_prod", prod, -16256);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
